// File: rtl/ctr_sync_updown_if.sv
// Control/status bundle for ctr_sync_updown.
// Defining CTR_SYNC_UPDOWN_CMP_EN adds the compare value and compare pulse signals.
interface ctr_sync_updown_if #(
  parameter int BIT_WIDTH = 16
);
  logic                 EN_I;
  logic                 UP_I;
  logic                 SAT_I;
  logic                 CLR_I;
  logic                 LOAD_I;
  logic [BIT_WIDTH-1:0] LOAD_VAL_I;
  logic                 FLAG_CLR_I;
  logic [BIT_WIDTH-1:0] CNT_O;
  logic                 TC_O;
  logic                 WRAP_O;
  logic                 OVF_O;
  logic                 UDF_O;
`ifdef CTR_SYNC_UPDOWN_CMP_EN
  logic [BIT_WIDTH-1:0] CMP_VAL_I;
  logic                 CMP_O;

  modport master (
    output EN_I, UP_I, SAT_I, CLR_I, LOAD_I, LOAD_VAL_I, FLAG_CLR_I, CMP_VAL_I,
    input  CNT_O, TC_O, WRAP_O, OVF_O, UDF_O, CMP_O
  );

  modport slave (
    input  EN_I, UP_I, SAT_I, CLR_I, LOAD_I, LOAD_VAL_I, FLAG_CLR_I, CMP_VAL_I,
    output CNT_O, TC_O, WRAP_O, OVF_O, UDF_O, CMP_O
  );
`else
  modport master (
    output EN_I, UP_I, SAT_I, CLR_I, LOAD_I, LOAD_VAL_I, FLAG_CLR_I,
    input  CNT_O, TC_O, WRAP_O, OVF_O, UDF_O
  );

  modport slave (
    input  EN_I, UP_I, SAT_I, CLR_I, LOAD_I, LOAD_VAL_I, FLAG_CLR_I,
    output CNT_O, TC_O, WRAP_O, OVF_O, UDF_O
  );
`endif
endinterface

// File: rtl/ctr_sync_updown.sv
// Synchronous up/down counter, range 0..MAX_VAL, wrap/saturate, sticky flags.
// Optional compare pulse output enabled by defining CTR_SYNC_UPDOWN_CMP_EN.
module ctr_sync_updown #(
  parameter int                   BIT_WIDTH = 16,
  parameter logic [BIT_WIDTH-1:0] RESET_VAL = '0,
  parameter logic [BIT_WIDTH-1:0] MAX_VAL   = {BIT_WIDTH{1'b1}}
) (
  input  logic             CLK_I,
  input  logic             RST_SYNC_I,
  ctr_sync_updown_if.slave bus
);

  localparam logic [BIT_WIDTH-1:0] ONE = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

  logic [BIT_WIDTH-1:0] r_cnt;
  logic                 r_wrap;
  logic                 r_ovf;
  logic                 r_udf;

  logic [BIT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_wrap_nxt;
  logic                 w_ovf_set;
  logic                 w_udf_set;
  logic                 w_at_max;
  logic                 w_at_zero;
  logic                 w_ovf_nxt;
  logic                 w_udf_nxt;

  assign w_at_max  = (r_cnt == MAX_VAL);
  assign w_at_zero = (r_cnt == '0);

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    w_ovf_set  = 1'b0;
    w_udf_set  = 1'b0;
    if (bus.CLR_I) begin
      w_cnt_nxt = '0;
    end else if (bus.LOAD_I) begin
      w_cnt_nxt = (bus.LOAD_VAL_I > MAX_VAL) ? MAX_VAL : bus.LOAD_VAL_I;
    end else if (bus.EN_I) begin
      if (bus.UP_I) begin
        if (w_at_max) begin
          w_ovf_set = 1'b1;
          if (!bus.SAT_I) begin
            w_cnt_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end else begin
        if (w_at_zero) begin
          w_udf_set = 1'b1;
          if (!bus.SAT_I) begin
            w_cnt_nxt  = MAX_VAL;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
    end
  end

  // A set in the same cycle as FLAG_CLR_I wins.
  assign w_ovf_nxt = w_ovf_set | (r_ovf & ~bus.FLAG_CLR_I);
  assign w_udf_nxt = w_udf_set | (r_udf & ~bus.FLAG_CLR_I);

  always_ff @(posedge CLK_I) begin
    if (RST_SYNC_I) begin
      r_cnt  <= RESET_VAL;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
      r_ovf  <= w_ovf_nxt;
      r_udf  <= w_udf_nxt;
    end
  end

  assign bus.CNT_O  = r_cnt;
  assign bus.WRAP_O = r_wrap;
  assign bus.OVF_O  = r_ovf;
  assign bus.UDF_O  = r_udf;
  assign bus.TC_O   = bus.EN_I & ((bus.UP_I & w_at_max) | (~bus.UP_I & w_at_zero));

`ifdef CTR_SYNC_UPDOWN_CMP_EN
  logic r_cmp;
  logic w_cmp_nxt;

  // Fires only on an actual change of value, so holds and saturation stay quiet.
  assign w_cmp_nxt = (w_cnt_nxt != r_cnt) && (w_cnt_nxt == bus.CMP_VAL_I);

  always_ff @(posedge CLK_I) begin
    if (RST_SYNC_I) begin
      r_cmp <= 1'b0;
    end else begin
      r_cmp <= w_cmp_nxt;
    end
  end

  assign bus.CMP_O = r_cmp;
`endif

endmodule

// File: tb/tb_ctr_sync_updown.sv
// Directed bench for ctr_sync_updown: BIT_WIDTH=4, MAX_VAL=11, RESET_VAL=5.
module tb_ctr_sync_updown;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ctr_sync_updown_if #(.BIT_WIDTH(4)) bus ();

  ctr_sync_updown #(
    .BIT_WIDTH(4),
    .RESET_VAL(4'd5),
    .MAX_VAL  (4'd11)
  ) dut (
    .CLK_I     (clk),
    .RST_SYNC_I(rst),
    .bus       (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.EN_I = 0; bus.UP_I = 1; bus.SAT_I = 0; bus.CLR_I = 0;
    bus.LOAD_I = 0; bus.LOAD_VAL_I = 4'd0; bus.FLAG_CLR_I = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; bus.EN_I = 1; bus.LOAD_I = 1; bus.LOAD_VAL_I = 4'd2;
    step(); step();
    vectors++; if (bus.CNT_O !== 4'd5) begin miscompares++; $display("FAIL rst_cnt got %0d want 5", bus.CNT_O); end
    vectors++; if (bus.WRAP_O !== 1'b0) begin miscompares++; $display("FAIL rst_wrap got %b want 0", bus.WRAP_O); end
    vectors++; if (bus.OVF_O !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got %b want 0", bus.OVF_O); end
    vectors++; if (bus.UDF_O !== 1'b0) begin miscompares++; $display("FAIL rst_udf got %b want 0", bus.UDF_O); end
    rst = 0; bus.LOAD_I = 0; bus.UP_I = 1;
    step();
    vectors++; if (bus.CNT_O !== 4'd6) begin miscompares++; $display("FAIL up1 got %0d want 6", bus.CNT_O); end
    step();
    vectors++; if (bus.CNT_O !== 4'd7) begin miscompares++; $display("FAIL up2 got %0d want 7", bus.CNT_O); end
  endtask

  task automatic test_up_wrap();
    idle();
    bus.LOAD_I = 1; bus.LOAD_VAL_I = 4'd10;
    step();
    vectors++; if (bus.CNT_O !== 4'd10) begin miscompares++; $display("FAIL load10 got %0d want 10", bus.CNT_O); end
    bus.LOAD_I = 0; bus.EN_I = 1; bus.UP_I = 1; bus.SAT_I = 0;
    #1;
    vectors++; if (bus.TC_O !== 1'b0) begin miscompares++; $display("FAIL tc_at10 got %b want 0", bus.TC_O); end
    step();
    vectors++; if (bus.CNT_O !== 4'd11) begin miscompares++; $display("FAIL up_to11 got %0d want 11", bus.CNT_O); end
    vectors++; if (bus.TC_O !== 1'b1) begin miscompares++; $display("FAIL tc_at11 got %b want 1", bus.TC_O); end
    vectors++; if (bus.OVF_O !== 1'b0) begin miscompares++; $display("FAIL ovf_pre got %b want 0", bus.OVF_O); end
    step();
    vectors++; if (bus.CNT_O !== 4'd0) begin miscompares++; $display("FAIL wrap_cnt got %0d want 0", bus.CNT_O); end
    vectors++; if (bus.WRAP_O !== 1'b1) begin miscompares++; $display("FAIL wrap_pulse got %b want 1", bus.WRAP_O); end
    vectors++; if (bus.OVF_O !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", bus.OVF_O); end
    bus.EN_I = 0;
    step();
    vectors++; if (bus.WRAP_O !== 1'b0) begin miscompares++; $display("FAIL wrap_end got %b want 0", bus.WRAP_O); end
    vectors++; if (bus.OVF_O !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", bus.OVF_O); end
    vectors++; if (bus.CNT_O !== 4'd0) begin miscompares++; $display("FAIL hold0 got %0d want 0", bus.CNT_O); end
  endtask

  task automatic test_down_sat();
    idle();
    bus.FLAG_CLR_I = 1;
    step();
    vectors++; if (bus.OVF_O !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got %b want 0", bus.OVF_O); end
    bus.FLAG_CLR_I = 0; bus.CLR_I = 1;
    step();
    vectors++; if (bus.CNT_O !== 4'd0) begin miscompares++; $display("FAIL clr got %0d want 0", bus.CNT_O); end
    bus.CLR_I = 0; bus.EN_I = 1; bus.UP_I = 0; bus.SAT_I = 1;
    #1;
    vectors++; if (bus.TC_O !== 1'b1) begin miscompares++; $display("FAIL tc_at0 got %b want 1", bus.TC_O); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (bus.CNT_O !== 4'd0) begin miscompares++; $display("FAIL sat0_cnt[%0d] got %0d want 0", i, bus.CNT_O); end
      vectors++; if (bus.UDF_O !== 1'b1) begin miscompares++; $display("FAIL sat0_udf[%0d] got %b want 1", i, bus.UDF_O); end
      vectors++; if (bus.WRAP_O !== 1'b0) begin miscompares++; $display("FAIL sat0_wrap[%0d] got %b want 0", i, bus.WRAP_O); end
    end
    bus.EN_I = 0; bus.FLAG_CLR_I = 1;
    step();
    vectors++; if (bus.UDF_O !== 1'b0) begin miscompares++; $display("FAIL udf_clr got %b want 0", bus.UDF_O); end
  endtask

  task automatic test_priority();
    idle();
    bus.LOAD_I = 1; bus.LOAD_VAL_I = 4'd3;
    step();
    vectors++; if (bus.CNT_O !== 4'd3) begin miscompares++; $display("FAIL load3 got %0d want 3", bus.CNT_O); end
    bus.CLR_I = 1; bus.LOAD_VAL_I = 4'd7; bus.EN_I = 1; bus.UP_I = 1;
    step();
    vectors++; if (bus.CNT_O !== 4'd0) begin miscompares++; $display("FAIL clr_wins got %0d want 0", bus.CNT_O); end
    bus.CLR_I = 0; bus.LOAD_VAL_I = 4'd15; bus.UP_I = 0; bus.SAT_I = 0;
    step();
    vectors++; if (bus.CNT_O !== 4'd11) begin miscompares++; $display("FAIL load_clamp got %0d want 11", bus.CNT_O); end
    vectors++; if (bus.UDF_O !== 1'b0) begin miscompares++; $display("FAIL load_udf got %b want 0", bus.UDF_O); end
    vectors++; if (bus.OVF_O !== 1'b0) begin miscompares++; $display("FAIL load_ovf got %b want 0", bus.OVF_O); end
    vectors++; if (bus.WRAP_O !== 1'b0) begin miscompares++; $display("FAIL load_wrap got %b want 0", bus.WRAP_O); end
  endtask

  task automatic test_flag_race();
    idle();
    bus.EN_I = 1; bus.UP_I = 1; bus.SAT_I = 1; bus.FLAG_CLR_I = 1;
    step();
    vectors++; if (bus.CNT_O !== 4'd11) begin miscompares++; $display("FAIL race_cnt got %0d want 11", bus.CNT_O); end
    vectors++; if (bus.OVF_O !== 1'b1) begin miscompares++; $display("FAIL race_ovf got %b want 1", bus.OVF_O); end
    vectors++; if (bus.WRAP_O !== 1'b0) begin miscompares++; $display("FAIL race_wrap got %b want 0", bus.WRAP_O); end
    bus.EN_I = 0;
    step();
    vectors++; if (bus.OVF_O !== 1'b0) begin miscompares++; $display("FAIL race_clr got %b want 0", bus.OVF_O); end
  endtask

  task automatic test_down_wrap();
    idle();
    bus.LOAD_I = 1; bus.LOAD_VAL_I = 4'd1;
    step();
    bus.LOAD_I = 0; bus.EN_I = 1; bus.UP_I = 0; bus.SAT_I = 0;
    step();
    vectors++; if (bus.CNT_O !== 4'd0) begin miscompares++; $display("FAIL dn_to0 got %0d want 0", bus.CNT_O); end
    step();
    vectors++; if (bus.CNT_O !== 4'd11) begin miscompares++; $display("FAIL dn_wrap got %0d want 11", bus.CNT_O); end
    vectors++; if (bus.WRAP_O !== 1'b1) begin miscompares++; $display("FAIL dn_wrap_pulse got %b want 1", bus.WRAP_O); end
    vectors++; if (bus.UDF_O !== 1'b1) begin miscompares++; $display("FAIL dn_udf got %b want 1", bus.UDF_O); end
    step();
    vectors++; if (bus.CNT_O !== 4'd10) begin miscompares++; $display("FAIL dn_to10 got %0d want 10", bus.CNT_O); end
    vectors++; if (bus.WRAP_O !== 1'b0) begin miscompares++; $display("FAIL dn_wrap_end got %b want 0", bus.WRAP_O); end
  endtask

`ifdef CTR_SYNC_UPDOWN_CMP_EN
  task automatic test_cmp();
    logic [3:0] exp_cnt;
    idle();
    bus.CMP_VAL_I = 4'd3; bus.CLR_I = 1;
    step();
    vectors++; if (bus.CMP_O !== 1'b0) begin miscompares++; $display("FAIL cmp_clr got %b want 0", bus.CMP_O); end
    bus.CLR_I = 0; bus.EN_I = 1; bus.UP_I = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_cnt = 4'(i);
      vectors++; if (bus.CNT_O !== exp_cnt) begin miscompares++; $display("FAIL cmp_cnt[%0d] got %0d want %0d", i, bus.CNT_O, exp_cnt); end
      vectors++; if (bus.CMP_O !== (i == 3)) begin miscompares++; $display("FAIL cmp_pulse[%0d] got %b want %b", i, bus.CMP_O, (i == 3)); end
    end
    bus.EN_I = 0;
    step();
    vectors++; if (bus.CMP_O !== 1'b0) begin miscompares++; $display("FAIL cmp_hold got %b want 0", bus.CMP_O); end
  endtask
`endif

  initial begin
    idle();
`ifdef CTR_SYNC_UPDOWN_CMP_EN
    bus.CMP_VAL_I = 4'd0;
`endif
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_priority();
    test_flag_race();
    test_down_wrap();
`ifdef CTR_SYNC_UPDOWN_CMP_EN
    test_cmp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
